// File: rtl/linear_loader_pkg.sv
// Shared types and default geometry for the linear_loader block.
package linear_loader_pkg;

  localparam int unsigned ROWS_DEF = 50;
  localparam int unsigned KDIM_DEF = 20;
  localparam int unsigned COLS_DEF = 20;
  localparam int unsigned DW_DEF   = 32;

  localparam int unsigned W_BEATS = KDIM_DEF * COLS_DEF;  // 400
  localparam int unsigned X_BEATS = ROWS_DEF * KDIM_DEF;  // 1000

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_X,
    START,
    WAIT,
    FIN
  } state_e;

  // Bits needed to hold the value n itself (used for limit ports).
  function automatic int unsigned val_width(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

  // Bits needed to index an array of n entries.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/loader_idx_ctr.sv
// Two-level row/column index counter with wrap and last-beat flag.
// Limits are runtime inputs so one instance serves both load phases.
module loader_idx_ctr
  import linear_loader_pkg::*;
#(
  parameter int unsigned ROW_W = 6,
  parameter int unsigned COL_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  input  logic [ROW_W-1:0] num_rows,
  input  logic [COL_W-1:0] num_cols,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             col_end;
  logic             row_end;

  // Next index: clear wins, otherwise step column-fastest on each advance.
  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    col_end = (col_q == num_cols - 1'b1);
    row_end = (row_q == num_rows - 1'b1);
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (adv) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Index registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = col_end && row_end;

endmodule

// File: rtl/linear_loader.sv
// Streams weight and input matrices into local buffers, then hands off
// to a matrix-multiply engine with a start/done handshake.
module linear_loader
  import linear_loader_pkg::*;
#(
  parameter int unsigned ROWS = ROWS_DEF,
  parameter int unsigned KDIM = KDIM_DEF,
  parameter int unsigned COLS = COLS_DEF,
  parameter int unsigned DW   = DW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 go,
  input  logic                 reload_w,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [DW-1:0] s_data,
  input  logic                 s_last,
  output logic signed [DW-1:0] weight     [KDIM][COLS],
  output logic signed [DW-1:0] input_data [ROWS][KDIM],
  output logic                 mm_start,
  input  logic                 mm_done,
  output logic                 busy,
  output logic                 job_done,
  output logic                 err
);

  localparam int unsigned ROW_W = val_width(max2(ROWS, KDIM));
  localparam int unsigned COL_W = val_width(max2(COLS, KDIM));
  localparam int unsigned WR_W  = sel_width(KDIM);
  localparam int unsigned WC_W  = sel_width(COLS);
  localparam int unsigned XR_W  = sel_width(ROWS);
  localparam int unsigned XC_W  = sel_width(KDIM);

  state_e state_q, state_d;
  logic   w_loaded_q, w_loaded_d;
  logic   err_q, err_d;

  logic signed [DW-1:0] weight_q [KDIM][COLS];
  logic signed [DW-1:0] input_q  [ROWS][KDIM];

  logic             hs;
  logic             w_we, x_we;
  logic             ctr_clr, ctr_adv, ctr_last;
  logic [ROW_W-1:0] ctr_row, ctr_rows;
  logic [COL_W-1:0] ctr_col, ctr_cols;
  logic [WR_W-1:0]  w_row;
  logic [WC_W-1:0]  w_col;
  logic [XR_W-1:0]  x_row;
  logic [XC_W-1:0]  x_col;

  // Ready is gated by rst_n so no beat is taken in a reset cycle.
  assign s_ready  = rst_n && ((state_q == LOAD_W) || (state_q == LOAD_X));
  assign hs       = s_valid && s_ready;
  assign busy     = (state_q != IDLE);
  assign mm_start = (state_q == START);
  assign job_done = (state_q == FIN);
  assign err      = err_q;

  assign ctr_rows = (state_q == LOAD_W) ? ROW_W'(KDIM) : ROW_W'(ROWS);
  assign ctr_cols = (state_q == LOAD_W) ? COL_W'(COLS) : COL_W'(KDIM);
  assign ctr_adv  = hs;

  assign w_row = ctr_row[WR_W-1:0];
  assign w_col = ctr_col[WC_W-1:0];
  assign x_row = ctr_row[XR_W-1:0];
  assign x_col = ctr_col[XC_W-1:0];

  loader_idx_ctr #(
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_idx (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (ctr_clr),
    .adv      (ctr_adv),
    .num_rows (ctr_rows),
    .num_cols (ctr_cols),
    .row      (ctr_row),
    .col      (ctr_col),
    .last     (ctr_last)
  );

  // Next-state, buffer write enables and counter clear.
  always_comb begin
    state_d    = state_q;
    w_loaded_d = w_loaded_q;
    err_d      = err_q;
    ctr_clr    = 1'b0;
    w_we       = 1'b0;
    x_we       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          err_d   = 1'b0;
          state_d = (reload_w || !w_loaded_q) ? LOAD_W : LOAD_X;
        end
      end
      LOAD_W: begin
        if (hs) begin
          if (s_last && !ctr_last) begin
            err_d   = 1'b1;
            ctr_clr = 1'b1;
            state_d = IDLE;
          end else begin
            w_we = 1'b1;
            if (ctr_last) begin
              w_loaded_d = 1'b1;
              ctr_clr    = 1'b1;
              state_d    = LOAD_X;
            end
          end
        end
      end
      LOAD_X: begin
        if (hs) begin
          if (s_last && !ctr_last) begin
            err_d   = 1'b1;
            ctr_clr = 1'b1;
            state_d = IDLE;
          end else begin
            x_we = 1'b1;
            if (ctr_last) begin
              ctr_clr = 1'b1;
              state_d = START;
            end
          end
        end
      end
      START:   state_d = WAIT;
      WAIT:    if (mm_done) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      w_loaded_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_loaded_q <= w_loaded_d;
      err_q      <= err_d;
    end
  end

  // Buffer writes on accepted beats only; contents are never reset.
  always_ff @(posedge clk) begin
    if (w_we) weight_q[w_row][w_col] <= s_data;
    if (x_we) input_q[x_row][x_col]  <= s_data;
  end

  assign weight     = weight_q;
  assign input_data = input_q;

endmodule

// File: doc/linear_loader.md
LINEAR_LOADER -- requirements
Module: linear_loader

Interface
REQ-001 Parameter ROWS, default 50: rows of the input matrix.
REQ-002 Parameter KDIM, default 20: input columns, which equal weight rows.
REQ-003 Parameter COLS, default 20: weight columns.
REQ-004 Parameter DW, default 32: data word width.
REQ-005 Port clk  in  1  single clock; all logic on its rising edge.
REQ-006 Port rst_n  in  1  reset; synchronous, active-low.
REQ-007 Port go  in  1  single-cycle command pulse that begins a load/compute job.
REQ-008 Port reload_w  in  1  sampled together with go; 1 forces a weight reload.
REQ-009 Port s_valid  in  1  stream beat valid.
REQ-010 Port s_ready  out  1  stream beat accepted when s_valid and s_ready are both high.
REQ-011 Port s_data  in  DW  signed stream word.
REQ-012 Port s_last  in  1  marks the final beat of the current load phase.
REQ-013 Port weight  out  [KDIM][COLS] x DW signed  weight buffer that drives the matrix-multiply weight port.
REQ-014 Port input_data  out  [ROWS][KDIM] x DW signed  input buffer that drives the matrix-multiply input port.
REQ-015 Port mm_start  out  1  start pulse to the matrix-multiply engine.
REQ-016 Port mm_done  in  1  done pulse from the matrix-multiply engine.
REQ-017 Port busy  out  1  high in every state except IDLE.
REQ-018 Port job_done  out  1  one-cycle pulse when a job completes.
REQ-019 Port err  out  1  sticky s_last framing error; cleared by the next accepted go.

Function
REQ-020 The FSM SHALL have the states IDLE, LOAD_W, LOAD_X, START, WAIT and FIN.
REQ-021 In IDLE, go SHALL move the FSM to LOAD_W if reload_w=1 or w_loaded=0, and to LOAD_X otherwise.
REQ-022 go SHALL be ignored in every state other than IDLE.
REQ-023 s_ready SHALL be 1 only in LOAD_W and LOAD_X, combinationally from state.
REQ-024 LOAD_W SHALL accept KDIM*COLS beats and write beat n to weight[n/COLS][n%COLS] (row-major, column index fastest).
REQ-025 LOAD_X SHALL accept ROWS*KDIM beats and write beat n to input_data[n/KDIM][n%KDIM].
REQ-026 Index counters SHALL advance only on handshake beats.
REQ-027 Index counters SHALL wrap column-to-zero / row+1, and SHALL clear to 0 on leaving each load state.
REQ-028 On the last weight beat, the FSM SHALL set w_loaded=1 and move to LOAD_X on the next cycle.
REQ-029 On the last input beat, the FSM SHALL move to START.
REQ-030 START SHALL assert mm_start for exactly one cycle, then move to WAIT.
REQ-031 mm_start SHALL therefore rise 1 cycle after the final input handshake.
REQ-032 WAIT SHALL hold until mm_done=1, then move to FIN.
REQ-033 mm_done seen in any state other than WAIT SHALL be ignored.
REQ-034 FIN SHALL assert job_done for one cycle and return to IDLE.
REQ-035 A beat with s_last=1 that is not the final beat of its phase SHALL set err=1, write nothing, clear the counters and return to IDLE.
REQ-036 A final beat with s_last=0 SHALL still be accepted normally; s_last is checked only for early assertion.
REQ-037 The buffers SHALL be written only on handshake beats, with no arithmetic and no width change.
REQ-038 Buffers SHALL hold their value during START, WAIT, FIN and IDLE.
REQ-039 Back-to-back jobs SHALL be supported: go may be asserted in the cycle after job_done.

Reset
REQ-040 Reset SHALL be sampled on the rising edge of clk while rst_n=0.
REQ-041 Reset SHALL apply from any state, including mid-load and WAIT.
REQ-042 Reset SHALL set state=IDLE, clear the counters, and set w_loaded=0, err=0, mm_start=0, job_done=0 and busy=0.
REQ-043 Reset SHALL force s_ready=0.
REQ-044 The buffer arrays SHALL have no reset; their contents are undefined until loaded.

Structure
REQ-045 The shared package SHALL hold the FSM state enum and the ROWS/KDIM/COLS/DW defaults.
REQ-046 The shared package SHALL hold the derived beat counts W_BEATS=400 and X_BEATS=1000.
REQ-047 One sub-module, loader_idx_ctr, SHALL implement the two-level row/column index counter with wrap and last-beat flag.
REQ-048 loader_idx_ctr SHALL be instantiated once and shared by both load phases.

Verification
REQ-049 Cold job: go, reload_w=0 after reset, 400 weight beats (value n), 1000 input beats (value 1000+n) -> weight[3][7]=67 and input_data[49][19]=1999; mm_start pulses 1 cycle after the last beat.
REQ-050 Weight reuse: second go with reload_w=0 -> FSM goes straight to LOAD_X; exactly 1000 beats are accepted; weight is unchanged.
REQ-051 Backpressure: s_valid toggled randomly with 30% idle cycles -> contents are identical to the gap-free load, with no duplicate or dropped beats.
REQ-052 Early s_last on input beat 500 -> err=1, FSM in IDLE, input_data[25][0] not written; next go clears err.
REQ-053 rst_n=0 for one cycle during WAIT -> IDLE next cycle, w_loaded=0, and a later mm_done produces no job_done.
REQ-054 Handshake: mm_done held at 1 for 3 cycles in WAIT -> exactly one job_done; go during LOAD_X has no effect.
